// File: rtl/wb_stage_buffer.sv
// MEM->WB stage register: valid/ready handshake over a head + skid pair of entries.
// Each lane picks its ALU or load result and drops r0 writes and same-bundle WAW losers at capture.

module wb_lane #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int K      = 0
) (
  input  logic [LANES-1:0]        reg_write,
  input  logic [LANES*REG_AW-1:0] write_reg,
  input  logic                    mem_to_reg,
  input  logic [DATA_W-1:0]       read_data,
  input  logic [DATA_W-1:0]       alu_out,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    qwe
);
  logic [REG_AW-1:0] rd_k;
  logic              kill;

  assign rd_k = write_reg[K*REG_AW +: REG_AW];

  // A younger lane (higher index) writing the same register supersedes this one.
  always_comb begin
    kill = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (j > K && reg_write[j] && write_reg[j*REG_AW +: REG_AW] == rd_k) kill = 1'b1;
    end
  end

  assign wb_data = mem_to_reg ? read_data : alu_out;
  assign qwe     = reg_write[K] & (rd_k != '0) & ~kill;
endmodule

module wb_stage_buffer #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        reg_write_i,
  input  logic [LANES-1:0]        mem_to_reg_i,
  input  logic [LANES*DATA_W-1:0] read_data_i,
  input  logic [LANES*DATA_W-1:0] alu_out_i,
  input  logic [LANES*REG_AW-1:0] write_reg_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        reg_write_o,
  output logic [LANES*DATA_W-1:0] wb_data_o,
  output logic [LANES*REG_AW-1:0] write_reg_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  typedef struct packed {
    logic [LANES-1:0]             qwe;
    logic [LANES-1:0][DATA_W-1:0] data;
    logic [LANES-1:0][REG_AW-1:0] addr;
  } entry_t;

  occ_e   state, state_nxt;
  entry_t cap, head, skid;
  logic   accept, pop, ld_head, ld_skid, mv_skid;

  logic [LANES-1:0][DATA_W-1:0] cap_data;
  logic [LANES-1:0]             cap_qwe;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    wb_lane #(.LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW), .K(k)) u_lane (
      .reg_write (reg_write_i),
      .write_reg (write_reg_i),
      .mem_to_reg(mem_to_reg_i[k]),
      .read_data (read_data_i[k*DATA_W +: DATA_W]),
      .alu_out   (alu_out_i[k*DATA_W +: DATA_W]),
      .wb_data   (cap_data[k]),
      .qwe       (cap_qwe[k])
    );
  end

  assign cap = {cap_qwe, cap_data, write_reg_i};

  // Handshake flags decode straight from the occupancy register.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_head   = 1'b0;
    ld_skid   = 1'b0;
    mv_skid   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          ld_head   = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            ld_head = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            ld_skid   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_nxt = ONE;
          mv_skid   = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (ld_head)      head <= cap;
      else if (mv_skid) head <= skid;
      if (ld_skid)      skid <= cap;
    end
  end

  assign reg_write_o = head.qwe & {LANES{out_valid}};
  assign wb_data_o   = head.data;
  assign write_reg_o = head.addr;
endmodule

// File: tb/tb_wb_stage_buffer.sv
// Bench for wb_stage_buffer: directed vector table, hand sequences and a random run
// checked against a queue-based model of the buffer.

module tb_wb_stage_buffer;
  localparam int L = 2, DW = 32, AW = 5;

  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [L-1:0]    reg_write_i = '0, mem_to_reg_i = '0;
  logic [L*DW-1:0] read_data_i = '0, alu_out_i = '0;
  logic [L*AW-1:0] write_reg_i = '0;
  logic            in_ready, out_valid;
  logic [L-1:0]    reg_write_o;
  logic [L*DW-1:0] wb_data_o;
  logic [L*AW-1:0] write_reg_o;

  wb_stage_buffer #(.LANES(L), .DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .read_data_i(read_data_i), .alu_out_i(alu_out_i), .write_reg_i(write_reg_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write_o(reg_write_o), .wb_data_o(wb_data_o), .write_reg_o(write_reg_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0]         we, m2r;
    logic [L-1:0][DW-1:0] rd, alu;
    logic [L-1:0][AW-1:0] wr;
  } bundle_t;

  typedef struct {
    logic [L-1:0]         qwe;
    logic [L-1:0][DW-1:0] data;
    logic [L-1:0][AW-1:0] wr;
  } exp_t;

  typedef struct {
    bundle_t     b;
    logic [L-1:0] exp_we;
    logic [L*DW-1:0] exp_data;
  } vec_t;

  int   errors = 0, checks = 0;
  exp_t q[$];
  bundle_t idle, ba, bb, bc;
  vec_t tbl[6];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t ref_proc(bundle_t b);
    exp_t e;
    for (int k = 0; k < L; k++) begin
      e.data[k] = b.m2r[k] ? b.rd[k] : b.alu[k];
      e.wr[k]   = b.wr[k];
      e.qwe[k]  = b.we[k] && (b.wr[k] != 0);
      for (int j = k + 1; j < L; j++)
        if (b.we[j] && b.wr[j] == b.wr[k]) e.qwe[k] = 1'b0;
    end
    return e;
  endfunction

  function automatic bundle_t mk(logic [L-1:0] we, logic [L-1:0] m2r, logic [L*DW-1:0] rd,
                                 logic [L*DW-1:0] alu, logic [L*AW-1:0] wr);
    bundle_t b;
    b.we = we; b.m2r = m2r; b.rd = rd; b.alu = alu; b.wr = wr;
    return b;
  endfunction

  function automatic bundle_t rand_b();
    bundle_t b;
    b.we  = L'($urandom);
    b.m2r = L'($urandom);
    for (int k = 0; k < L; k++) begin
      b.rd[k]  = $urandom;
      b.alu[k] = $urandom;
      b.wr[k]  = AW'($urandom_range(0, 3));
    end
    return b;
  endfunction

  task automatic model_check();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("reg_write_o", reg_write_o, q[0].qwe);
      chk("wb_data_o", wb_data_o, q[0].data);
      chk("write_reg_o", write_reg_o, q[0].wr);
    end else begin
      chk("reg_write_o_idle", reg_write_o, '0);
    end
  endtask

  // Called at a negedge: check current state, drive inputs for the next posedge, advance model.
  task automatic cycle(bit v, bundle_t b, bit ordy, bit fl);
    bit acc, pp;
    model_check();
    in_valid = v; out_ready = ordy; flush = fl;
    reg_write_i = b.we; mem_to_reg_i = b.m2r;
    read_data_i = b.rd; alu_out_i = b.alu; write_reg_i = b.wr;
    acc = v && (q.size() < 2);
    pp  = ordy && (q.size() != 0);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(ref_proc(b));
    end
    @(negedge clk);
  endtask

  initial begin
    idle = mk('0, '0, '0, '0, '0);
    ba = mk(2'b11, 2'b00, {32'h0, 32'h0}, {32'hA1, 32'hA0}, {5'd2, 5'd1});
    bb = mk(2'b11, 2'b11, {32'hB1, 32'hB0}, {32'h0, 32'h0}, {5'd4, 5'd3});
    bc = mk(2'b11, 2'b00, {32'h0, 32'h0}, {32'hC1, 32'hC0}, {5'd6, 5'd5});

    tbl[0] = '{mk(2'b11, 2'b01, {32'h33, 32'h11}, {32'h44, 32'h22}, {5'd0, 5'd5}), 2'b01, {32'h44, 32'h11}};
    tbl[1] = '{mk(2'b11, 2'b00, {32'h0, 32'h0}, {32'hB, 32'hA}, {5'd7, 5'd7}), 2'b10, {32'hB, 32'hA}};
    tbl[2] = '{mk(2'b01, 2'b10, {32'h55, 32'h0}, {32'h0, 32'h66}, {5'd7, 5'd7}), 2'b01, {32'h55, 32'h66}};
    tbl[3] = '{mk(2'b00, 2'b00, {32'h0, 32'h0}, {32'h12, 32'h34}, {5'd3, 5'd3}), 2'b00, {32'h12, 32'h34}};
    tbl[4] = '{mk(2'b11, 2'b11, {32'hDEAD, 32'hBEEF}, {32'h0, 32'h0}, {5'd3, 5'd9}), 2'b11, {32'hDEAD, 32'hBEEF}};
    tbl[5] = '{mk(2'b10, 2'b00, {32'h0, 32'h0}, {32'h77, 32'h88}, {5'd0, 5'd0}), 2'b00, {32'h77, 32'h88}};

    // Reset held while upstream offers a bundle.
    in_valid = 1'b1; reg_write_i = 2'b11; write_reg_i = {5'd3, 5'd4};
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_reg_write", reg_write_o, '0);
    chk("rst_wb_data", wb_data_o, '0);
    chk("rst_write_reg", write_reg_o, '0);
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // Streaming: four bundles back to back, each visible the following cycle.
    for (int i = 0; i < 4; i++)
      cycle(1, mk(2'b01, 2'b00, '0, {32'h0, 32'(i + 16)}, {5'd0, 5'(i + 1)}), 1, 0);
    chk("stream_last", wb_data_o[DW-1:0], 32'd19);
    cycle(0, idle, 1, 0);

    // Backpressure: A then B fills the buffer; drain gives A then B.
    cycle(1, ba, 0, 0);
    cycle(1, bb, 0, 0);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head_A", wb_data_o, {32'hA1, 32'hA0});
    cycle(1, bc, 0, 0);
    chk("bp_hold_A", wb_data_o, {32'hA1, 32'hA0});
    cycle(0, idle, 1, 0);
    chk("bp_head_B", wb_data_o, {32'hB1, 32'hB0});
    chk("bp_ready_again", in_ready, 1'b1);
    cycle(0, idle, 1, 0);
    chk("bp_drained", out_valid, 1'b0);

    // Lane mux, r0 squash and WAW vectors.
    foreach (tbl[i]) begin
      cycle(1, tbl[i].b, 1, 0);
      chk($sformatf("vec%0d_we", i), reg_write_o, tbl[i].exp_we);
      chk($sformatf("vec%0d_data", i), wb_data_o, tbl[i].exp_data);
      cycle(0, idle, 1, 0);
    end

    // Flush while full with a bundle offered: nothing survives.
    cycle(1, ba, 0, 0);
    cycle(1, bb, 0, 0);
    cycle(1, bc, 0, 1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_we", reg_write_o, '0);
    cycle(0, idle, 1, 0);
    chk("flush_no_C", out_valid, 1'b0);

    // Reset in the middle of a full buffer drops everything immediately.
    cycle(1, ba, 0, 0);
    cycle(1, bb, 0, 0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0; #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_we", reg_write_o, '0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 3) != 0, rand_b(), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    model_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
